// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the instruction/data memory arbiter.
//   WORD_W           - data and address width of the core's memory bus
//   DEPTH_DEF        - default number of memory words
//   STARVE_LIMIT_DEF - default denied-fetch cycles before fetch is forced through
//   owner_e          - which requester owns the response coming back next cycle
package mem_arb_pkg;
   localparam int unsigned WORD_W           = 16;
   localparam int unsigned DEPTH_DEF        = 256;
   localparam int unsigned STARVE_LIMIT_DEF = 4;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   // Out-of-range check done at 17 bits so a full 64K-word DEPTH still works.
   function automatic logic addr_oor(word_t a, int unsigned depth);
      return {1'b0, a} >= 17'(depth);
   endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and memory port of the arbiter.
//   slave  - arbiter side (takes requests and mem_rdata, drives grants,
//            responses and the memory address/write lines)
//   master - environment side (requesters plus the memory itself)
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic  if_req;
   word_t if_addr;
   logic  if_gnt;
   logic  if_rvalid;
   word_t if_rdata;
   logic  if_err;

   logic  d_req;
   logic  d_we;
   word_t d_addr;
   word_t d_wdata;
   logic  d_gnt;
   logic  d_rvalid;
   word_t d_rdata;
   logic  d_err;

   word_t mem_addr;
   word_t mem_wdata;
   logic  mem_we;
   word_t mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, if_err,
             d_gnt, d_rvalid, d_rdata, d_err,
             mem_addr, mem_wdata, mem_we
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, if_err,
             d_gnt, d_rvalid, d_rdata, d_err,
             mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: counts cycles in which fetch is asking but data is
// granted; once the count reaches STARVE_LIMIT, force_if makes fetch win.
//   clk, rst_n - clock, async active-low reset
//   if_req     - fetch is requesting
//   d_gnt      - data was granted this cycle
//   if_gnt     - fetch was granted this cycle
//   force_if   - fetch must win the next contested cycle
module mem_arb_starve_ctr #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic d_gnt,
   input  logic if_gnt,
   output logic force_if
);
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] cnt_q;

   // Can never pass STARVE_LIMIT: at the limit fetch is either granted or
   // not requesting, and both clear the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt_q <= '0;
      else if (!if_req || if_gnt) cnt_q <= '0;
      else if (d_gnt)             cnt_q <= cnt_q + CW'(1);
   end

   assign force_if = (cnt_q == CW'(STARVE_LIMIT));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between the fetch
// port and the load/store port. One grant per cycle, data first; the memory's
// one-cycle read latency is tracked with an owner tag so rdata returns to the
// requester that issued the read. Addresses >= DEPTH are granted but never
// reach the array; they answer next cycle with err=1, rdata=0.
//   clk, rst_n - clock, async active-low reset
//   bus        - mem_arbiter_if.slave (fetch, data and memory ports)
// Optional feature: define MEM_ARB_STARVE_EN to force a fetch grant after
// STARVE_LIMIT consecutive denied fetch cycles.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH        = DEPTH_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);
   logic   force_if;
   logic   if_win, d_win, any_win, oor;
   word_t  sel_addr;
   owner_e own_q, own_d;
   logic   err_q, err_d;

`ifdef MEM_ARB_STARVE_EN
   mem_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (bus.if_req),
      .d_gnt    (d_win),
      .if_gnt   (if_win),
      .force_if (force_if)
   );
`else
   assign force_if = 1'b0;
`endif

   // Arbitration; grants are gated by reset so nothing leaks out while held.
   always_comb begin
      d_win    = rst_n & bus.d_req & ~(force_if & bus.if_req);
      if_win   = rst_n & bus.if_req & ~d_win;
      any_win  = d_win | if_win;
      sel_addr = d_win ? bus.d_addr : (if_win ? bus.if_addr : '0);
      oor      = any_win & addr_oor(sel_addr, DEPTH);
   end

   assign bus.d_gnt     = d_win;
   assign bus.if_gnt    = if_win;
   assign bus.mem_addr  = oor ? '0 : sel_addr;
   assign bus.mem_we    = d_win & bus.d_we & ~oor;
   assign bus.mem_wdata = (d_win & bus.d_we & ~oor) ? bus.d_wdata : '0;

   // Owner tag: who gets the memory's output next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         own_q <= OWN_NONE;
         err_q <= 1'b0;
      end else begin
         own_q <= own_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      own_d         = OWN_NONE;
      err_d         = oor;
      bus.if_rvalid = 1'b0;
      bus.if_err    = 1'b0;
      bus.if_rdata  = '0;
      bus.d_rvalid  = 1'b0;
      bus.d_err     = 1'b0;
      bus.d_rdata   = '0;

      // In-range writes have no response, so they leave the tag at NONE.
      if (if_win)                            own_d = OWN_IF;
      else if (d_win && (!bus.d_we || oor))  own_d = OWN_D;

      // An errored access never got to the array: return zeros, not mem_rdata.
      case (own_q)
         OWN_IF: begin
            bus.if_rvalid = 1'b1;
            bus.if_err    = err_q;
            bus.if_rdata  = err_q ? '0 : bus.mem_rdata;
         end
         OWN_D: begin
            bus.d_rvalid = 1'b1;
            bus.d_err    = err_q;
            bus.d_rdata  = err_q ? '0 : bus.mem_rdata;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test-plan steps followed by a randomized phase,
// each cycle checked against a transaction-level model of the arbiter
// (priority rule, starvation count, shadow memory, one-deep response slot).
module tb_mem_arbiter;
   import mem_arb_pkg::*;

`ifdef MEM_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(.DEPTH(256), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Environment memory: 256 x 16, registered read, plus a preload port.
   logic [15:0] mem [256];
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;
   always @(posedge clk) begin
      if (ld_en)            mem[ld_addr] <= ld_data;
      else if (bus.mem_we)  mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[7:0]];
   end

   // Reference model state
   logic [15:0] shadow [256];
   bit          pend_v, pend_d, pend_err;
   logic [15:0] pend_data;
   int          starve_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Last observed DUT values
   logic        o_ig, o_dg, o_irv, o_drv, o_ierr, o_derr, o_mwe;
   logic [15:0] o_ird, o_drd, o_maddr, o_mwd;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One cycle: inputs already driven at the falling edge.
   task automatic step();
      bit          e_ig, e_dg, force_if, oor, e_we;
      logic [15:0] addr, e_maddr, e_mwd;
      if (!rst_n) begin
         pend_v     = 0;
         starve_cnt = 0;
      end
      force_if = STARVE && (starve_cnt == 4);
      e_dg  = rst_n && bus.d_req && !(force_if && bus.if_req);
      e_ig  = rst_n && bus.if_req && !e_dg;
      addr  = e_dg ? bus.d_addr : bus.if_addr;
      oor   = (e_dg || e_ig) && (int'(addr) >= 256);
      e_we  = e_dg && bus.d_we && !oor;
      e_maddr = ((e_dg || e_ig) && !oor) ? addr : 16'h0;
      e_mwd   = e_we ? bus.d_wdata : 16'h0;
      #1;
      o_ig = bus.if_gnt;  o_dg = bus.d_gnt;
      o_irv = bus.if_rvalid; o_ierr = bus.if_err; o_ird = bus.if_rdata;
      o_drv = bus.d_rvalid;  o_derr = bus.d_err;  o_drd = bus.d_rdata;
      o_maddr = bus.mem_addr; o_mwd = bus.mem_wdata; o_mwe = bus.mem_we;
      chk("if_gnt",    16'(o_ig),   16'(e_ig));
      chk("d_gnt",     16'(o_dg),   16'(e_dg));
      chk("mem_addr",  o_maddr,     e_maddr);
      chk("mem_we",    16'(o_mwe),  16'(e_we));
      chk("mem_wdata", o_mwd,       e_mwd);
      chk("if_rvalid", 16'(o_irv),  16'(pend_v && !pend_d));
      chk("if_err",    16'(o_ierr), 16'(pend_v && !pend_d && pend_err));
      chk("if_rdata",  o_ird,       (pend_v && !pend_d) ? pend_data : 16'h0);
      chk("d_rvalid",  16'(o_drv),  16'(pend_v && pend_d));
      chk("d_err",     16'(o_derr), 16'(pend_v && pend_d && pend_err));
      chk("d_rdata",   o_drd,       (pend_v && pend_d) ? pend_data : 16'h0);
      @(posedge clk);
      if (rst_n) begin
         pend_v    = e_ig || (e_dg && (!bus.d_we || oor));
         pend_d    = e_dg;
         pend_err  = oor;
         pend_data = oor ? 16'h0 : shadow[addr[7:0]];
         if (e_we) shadow[addr[7:0]] = bus.d_wdata;
         if (!bus.if_req || e_ig) starve_cnt = 0;
         else if (e_dg)           starve_cnt++;
      end
      @(negedge clk);
   endtask

   function automatic logic [15:0] rand_addr();
      int unsigned r = $urandom;
      if (r % 8 == 0) return 16'(256 + (r >> 3) % 65280);
      return 16'(r % 16);
   endfunction

   initial begin
      int first_if;
      bus.if_req = 0; bus.if_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      pend_v = 0; pend_d = 0; pend_err = 0; pend_data = '0; starve_cnt = 0;

      // Preload memory while in reset
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         ld_en = 1; ld_addr = 8'(i);
         ld_data = (i == 5) ? 16'h1234 : 16'($urandom);
         shadow[i] = ld_data;
         @(negedge clk);
      end
      ld_en = 0;

      // Reset state: requests present but everything must stay 0
      bus.if_req = 1; bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h3; bus.d_wdata = 16'h55AA;
      step();
      chk("rst_d_gnt", 16'(o_dg), 16'h0);

      // Reset release: fetch of address 5
      rst_n = 1;
      bus.d_req = 0; bus.d_we = 0; bus.if_req = 1; bus.if_addr = 16'd5;
      step();
      chk("t1_if_gnt", 16'(o_ig), 16'h1);
      bus.if_req = 0;
      step();
      chk("t1_if_rdata", o_ird, 16'h1234);
      chk("t1_if_rvalid", 16'(o_irv), 16'h1);

      // Contention: data write BEEF to 7 beats fetch read of 7
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'd7; bus.d_wdata = 16'hBEEF;
      bus.if_req = 1; bus.if_addr = 16'd7;
      step();
      chk("t2_d_gnt", 16'(o_dg), 16'h1);
      bus.d_req = 0; bus.d_we = 0;
      step();
      chk("t2_if_gnt", 16'(o_ig), 16'h1);
      bus.if_req = 0;
      step();
      chk("t2_if_rdata", o_ird, 16'hBEEF);

      // Back-to-back data reads 1,2,3
      bus.d_req = 1; bus.d_we = 0;
      for (int a = 1; a <= 3; a++) begin
         bus.d_addr = 16'(a);
         step();
      end
      bus.d_req = 0;
      step();
      chk("t3_d_rdata3", o_drd, shadow[3]);

      // Out-of-range write: granted, never written, error response
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0100; bus.d_wdata = 16'hAAAA;
      step();
      chk("t4_mem_we", 16'(o_mwe), 16'h0);
      bus.d_req = 0; bus.d_we = 0;
      step();
      chk("t4_d_err", 16'(o_derr), 16'h1);
      chk("t4_mem0", mem[0], shadow[0]);

      // Starvation: both ports hold requests
      bus.d_req = 1; bus.d_addr = 16'd2; bus.if_req = 1; bus.if_addr = 16'd3;
      first_if = -1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (o_ig && first_if < 0) first_if = c;
      end
      chk("t5_first_if_gnt", 16'(first_if), STARVE ? 16'd4 : 16'hFFFF);
      bus.d_req = 0; bus.if_req = 0;
      step();

      // Reset in the cycle after a read grant
      bus.d_req = 1; bus.d_addr = 16'd1;
      step();
      rst_n = 0; bus.d_req = 0;
      step();
      chk("t6_rst_d_rvalid", 16'(o_drv), 16'h0);
      bus.d_req = 1; bus.if_req = 1;
      step();
      rst_n = 1; bus.d_req = 0; bus.if_req = 0;
      step();
      chk("t6_post_d_rvalid", 16'(o_drv), 16'h0);

      // Randomized traffic; an ungranted requester holds its request
      for (int c = 0; c < 400; c++) begin
         if (!(bus.if_req && !o_ig)) begin
            bus.if_req  = ($urandom % 3) != 0;
            bus.if_addr = rand_addr();
         end
         if (!(bus.d_req && !o_dg)) begin
            bus.d_req   = ($urandom % 3) != 0;
            bus.d_we    = $urandom % 2;
            bus.d_addr  = rand_addr();
            bus.d_wdata = 16'($urandom);
         end
         step();
      end
      bus.if_req = 0; bus.d_req = 0;
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-cycle arbiter that shares the 256-word, 16-bit synchronous memory between the instruction-fetch port and the load/store data port of the 16-bit RISC core. Grants at most one access per cycle and drives the memory's `addr`/`wdata`/`we` inputs. Tracks the memory's one-cycle registered read latency and steers `rdata` back to the requester that issued the read. Also flags out-of-range addresses instead of letting them alias into the array.

## Interface
- `DEPTH`, 256: number of memory words; addresses `>= DEPTH` are out of range.
- `STARVE_LIMIT`, 4: consecutive denied fetch cycles before fetch is forced to win (used only with `MEM_ARB_STARVE_EN`).
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `if_req`  in  1  fetch read request.
- `if_addr`  in  16  fetch word address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch response valid.
- `if_rdata`  out  16  fetch read data.
- `if_err`  out  1  fetch response is out-of-range.
- `d_req`  in  1  data request.
- `d_we`  in  1  data request is a write.
- `d_addr`  in  16  data word address.
- `d_wdata`  in  16  data write value.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data response valid.
- `d_rdata`  out  16  data read data.
- `d_err`  out  1  data response is out-of-range.
- `mem_addr`  out  16  to memory `addr`.
- `mem_wdata`  out  16  to memory `wdata`.
- `mem_we`  out  1  to memory `we`.
- `mem_rdata`  in  16  from memory `rdata`.

## Operation
- **Arbitration.** Combinational, every cycle.
  - Default priority: data over fetch.
  - Exactly one of `if_gnt`/`d_gnt` is high when any request is present; both are low when there is no request.
  - A request is complete in its grant cycle. A requester that is not granted holds its request and payload stable.
- **Memory drive.** The winner's address (and write data and `d_we`, for a data write) goes to the memory port in the grant cycle. With no grant: `mem_addr`=0, `mem_wdata`=0, `mem_we`=0.
- **Out-of-range access** (address `>= DEPTH`):
  - The request is still granted.
  - `mem_we` is forced 0 and `mem_addr` is driven 0.
  - A response is always produced, for reads and writes alike: `rvalid`=1, `err`=1, `rdata`=0.
- **In-range write.** Produces no response; the grant is the acknowledge.
- **In-range read.** Produces a response with `err`=0.
- **Response tracking.** A registered owner tag (NONE/IF/D) plus a registered error flag are captured at each grant. Responses cannot be stalled; requesters must accept them.
- **State machine.** The owner tag is the only FSM.
  - NONE→IF on a fetch grant; NONE→D on a data read or error grant.
  - Any state→NONE on an idle cycle or an in-range write.
  - IF↔D transitions directly on back-to-back grants.

## Timing
- Request at cycle N → grant and memory drive in cycle N → memory samples at the N/N+1 edge → response in cycle N+1: `*_rvalid` for one cycle, `*_rdata` = `mem_rdata`.
- Fully pipelined: back-to-back grants every cycle, each producing its response one cycle later, in order.
- The non-owning port's `rvalid`/`err` are 0 and its `rdata` is 0.
- **Reset values:**
  - `if_gnt`, `d_gnt`: 0, gated while `rst_n`=0.
  - All `rvalid`, `err`, and `rdata` outputs: 0.
  - `mem_we`, `mem_addr`, `mem_wdata`: 0.
  - Owner tag: NONE.
  - Starvation counter: 0.
- **Reset mid-read:** the in-flight response is dropped; no `rvalid` follows reset release.
- **Simultaneous requests:** one winner; the loser is served at the earliest the cycle after.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - A counter increments in every cycle in which `if_req`=1 and `d_gnt`=1.
  - When the counter equals `STARVE_LIMIT`, fetch wins the next contested cycle.
  - The counter clears on any `if_gnt` or any cycle with `if_req`=0.
- `MEM_ARB_STARVE_EN` undefined: strict data priority; the counter is absent.

## Structure
- Package `mem_arb_pkg` holds:
  - The owner enum (`OWN_NONE`, `OWN_IF`, `OWN_D`).
  - The default `DEPTH` and `STARVE_LIMIT` constants.
  - The 16-bit word/address width constant.
- Optional sub-module `mem_arb_starve_ctr` holds the starvation counter and force-fetch output. It is instantiated only under `MEM_ARB_STARVE_EN`.

## Test plan
- **Reset release:** memory preloaded `MEM[5]`=`0x1234`, then `if_req`=1 with `if_addr`=5 in cycle 0 → `if_gnt`=1 in cycle 0; `if_rvalid`=1 with `if_rdata`=`0x1234` and `if_err`=0 in cycle 1.
- **Contention:** `if_req` and `d_req` both high (data write `0xBEEF` to address 7, fetch read of 7) → `d_gnt` in cycle 0, `if_gnt` in cycle 1, `if_rdata`=`0xBEEF` in cycle 2.
- **Back-to-back reads:** data reads of addresses 1, 2, 3 in consecutive cycles → `d_rvalid` high for three consecutive cycles with data in order.
- **Out-of-range write:** `d_addr`=`0x0100`, `d_we`=1 → `mem_we`=0 and `MEM[0]` unchanged; next cycle `d_rvalid`=1, `d_err`=1, `d_rdata`=0.
- **Starvation** (`MEM_ARB_STARVE_EN` defined): `d_req` and `if_req` held high continuously → `d_gnt` for 4 cycles, `if_gnt` in cycle 4, then `d_gnt` again. With the macro undefined → `if_gnt` never asserts.
- **Reset mid-read:** assert `rst_n`=0 in the cycle after a read grant → no `rvalid` after release; all outputs 0 during reset.
